// File: rtl/pcecd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcecd_pkg
// Purpose  : Shared bus-phase codes, status bits and initiator states for the
//            PC Engine CD-ROM bus (initiator and drive model).
// Revision : 1.0 - initial release
// ============================================================================
package pcecd_pkg;

    // Bus phase codes, ordered {msg, cd, io}
    localparam logic [2:0] PHASE_DATA_OUT    = 3'b000;
    localparam logic [2:0] PHASE_DATA_IN     = 3'b001;
    localparam logic [2:0] PHASE_COMMAND     = 3'b010;
    localparam logic [2:0] PHASE_STATUS      = 3'b011;
    localparam logic [2:0] PHASE_MESSAGE_OUT = 3'b110;
    localparam logic [2:0] PHASE_MESSAGE_IN  = 3'b111;

    // $1800 status register bit masks
    localparam logic [7:0] STS_BUSY = 8'h80;
    localparam logic [7:0] STS_REQ  = 8'h40;
    localparam logic [7:0] STS_MSG  = 8'h20;
    localparam logic [7:0] STS_CD   = 8'h10;
    localparam logic [7:0] STS_IO   = 8'h08;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SELECT      = 3'd1,
        ST_WAIT_REQ    = 3'd2,
        ST_ACK_HI      = 3'd3,
        ST_WAIT_REQ_LO = 3'd4,
        ST_BUS_RESET   = 3'd5
    } init_state_t;

    function automatic logic [2:0] bus_phase(input logic msg, input logic cd, input logic io);
        return {msg, cd, io};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcecd_timeout.sv
`default_nettype none
// ============================================================================
// Module   : pcecd_timeout
// Purpose  : Loadable down-counter; o_expired flags a count of zero.
// Revision : 1.0 - initial release
// ============================================================================
module pcecd_timeout #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Not gated by i_load: the owner's reload depends on its next state,
    // which in turn depends on expiry.
    assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pcecd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : pcecd_initiator
// Purpose  : Host-side PC Engine CD-ROM bus initiator: select, command out,
//            data-in stream, status/message capture, timeout bus reset.
// Revision : 1.0 - initial release
// ============================================================================
module pcecd_initiator
    import pcecd_pkg::*;
#(
    parameter int CMD_MAX_LEN    = 10,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int ACK_HOLD       = 2,
    parameter int RST_CYCLES     = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_wr,
    input  logic [3:0] i_cmd_addr,
    input  logic [7:0] i_cmd_data,
    input  logic [3:0] i_cmd_len,
    input  logic       i_start,
    input  logic       i_bsy,
    input  logic       i_req,
    input  logic       i_msg,
    input  logic       i_cd,
    input  logic       i_io,
    input  logic [7:0] i_db,
    output logic       o_sel,
    output logic       o_ack,
    output logic       o_rst,
    output logic [7:0] o_db,
    output logic [7:0] o_din_data,
    output logic       o_din_valid,
    input  logic       i_din_ready,
    output logic [7:0] o_status,
    output logic [7:0] o_message,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic       o_timeout
);

    localparam logic [4:0] c_len_max = 5'(CMD_MAX_LEN);
    localparam int         c_tmo_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int         c_hold_w  = $clog2(ACK_HOLD + 1);
    localparam int         c_rstc_w  = $clog2(RST_CYCLES + 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_load  = c_tmo_w'(TIMEOUT_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(ACK_HOLD - 1);
    localparam logic [c_rstc_w-1:0] c_rst_load  = c_rstc_w'(RST_CYCLES - 1);

    init_state_t r_state, w_state_nx;

    logic [7:0]          r_cmd [CMD_MAX_LEN];
    logic [3:0]          r_len, w_len_nx;
    logic [3:0]          r_idx, w_idx_nx;
    logic [c_hold_w-1:0] r_hold, w_hold_nx;
    logic [c_rstc_w-1:0] r_rst_cnt, w_rst_cnt_nx;
    logic                r_msg_seen, w_msg_seen_nx;
    logic                r_sel, w_sel_nx;
    logic                r_ack, w_ack_nx;
    logic                r_rst, w_rst_nx;
    logic [7:0]          r_db, w_db_nx;
    logic [7:0]          r_din_data, w_din_data_nx;
    logic                r_din_valid, w_din_valid_nx;
    logic [7:0]          r_status, w_status_nx;
    logic [7:0]          r_message, w_message_nx;
    logic                r_busy, w_busy_nx;
    logic                r_done, w_done_nx;
    logic                r_error, w_error_nx;
    logic                r_timeout, w_timeout_nx;

    logic       w_phase_ack;
    logic       w_len_bad;
    logic       w_tmo_hit;
    logic       w_tmo_load;
    logic       w_expired;
    logic [2:0] w_phase;

    assign w_phase   = bus_phase(i_msg, i_cd, i_io);
    assign w_len_bad = (i_cmd_len == 4'd0) || ({1'b0, i_cmd_len} > c_len_max);
    assign w_tmo_hit = w_expired && (r_state != ST_IDLE) && (r_state != ST_BUS_RESET);
    // A stalled data-in sink is not lack of bus progress
    assign w_tmo_load = (r_state == ST_IDLE) || (w_state_nx != r_state) ||
                        (r_din_valid && !i_din_ready);

    pcecd_timeout #(
        .WIDTH (c_tmo_w)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (w_tmo_load),
        .i_value   (c_tmo_load),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_cmd_wr && (r_state == ST_IDLE) && ({1'b0, i_cmd_addr} < c_len_max)) begin
            r_cmd[i_cmd_addr] <= i_cmd_data;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_len_nx       = r_len;
        w_idx_nx       = r_idx;
        w_hold_nx      = r_hold;
        w_rst_cnt_nx   = r_rst_cnt;
        w_msg_seen_nx  = r_msg_seen;
        w_sel_nx       = r_sel;
        w_ack_nx       = r_ack;
        w_rst_nx       = r_rst;
        w_db_nx        = r_db;
        w_din_data_nx  = r_din_data;
        w_din_valid_nx = r_din_valid;
        w_status_nx    = r_status;
        w_message_nx   = r_message;
        w_busy_nx      = r_busy;
        w_done_nx      = 1'b0;
        w_error_nx     = r_error;
        w_timeout_nx   = 1'b0;
        w_phase_ack    = 1'b0;

        if (w_tmo_hit) begin
            w_state_nx     = ST_BUS_RESET;
            w_sel_nx       = 1'b0;
            w_ack_nx       = 1'b0;
            w_rst_nx       = 1'b1;
            w_din_valid_nx = 1'b0;
            w_rst_cnt_nx   = c_rst_load;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_bsy) begin
                        w_len_nx      = i_cmd_len;
                        w_idx_nx      = 4'd0;
                        w_msg_seen_nx = 1'b0;
                        w_error_nx    = 1'b0;
                        if (w_len_bad) begin
                            w_error_nx = 1'b1;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_sel_nx   = 1'b1;
                            w_busy_nx  = 1'b1;
                            w_state_nx = ST_SELECT;
                        end
                    end
                end
                ST_SELECT: begin
                    if (i_bsy) begin
                        w_sel_nx   = 1'b0;
                        w_state_nx = ST_WAIT_REQ;
                    end
                end
                ST_WAIT_REQ: begin
                    // Bus free wins over a simultaneous request
                    if (!i_bsy) begin
                        w_busy_nx      = 1'b0;
                        w_done_nx      = 1'b1;
                        w_din_valid_nx = 1'b0;
                        w_state_nx     = ST_IDLE;
                        if (!r_msg_seen) begin
                            w_error_nx = 1'b1;
                        end
                    end else if (i_req) begin
                        case (w_phase)
                            PHASE_COMMAND: begin
                                w_phase_ack = 1'b1;
                                if (r_idx < r_len) begin
                                    w_db_nx = r_cmd[r_idx];
                                end else begin
                                    w_db_nx    = 8'h00;
                                    w_error_nx = 1'b1;
                                end
                                if (r_idx != 4'hF) begin
                                    w_idx_nx = r_idx + 4'd1;
                                end
                            end
                            PHASE_DATA_IN: begin
                                if (!r_din_valid) begin
                                    w_din_valid_nx = 1'b1;
                                    w_din_data_nx  = i_db;
                                end else if (i_din_ready) begin
                                    w_din_valid_nx = 1'b0;
                                    w_phase_ack    = 1'b1;
                                end
                            end
                            PHASE_STATUS: begin
                                w_phase_ack = 1'b1;
                                w_status_nx = i_db;
                            end
                            PHASE_MESSAGE_IN: begin
                                w_phase_ack   = 1'b1;
                                w_message_nx  = i_db;
                                w_msg_seen_nx = 1'b1;
                            end
                            default: begin
                                w_phase_ack = 1'b1;
                                w_db_nx     = 8'h00;
                                w_error_nx  = 1'b1;
                            end
                        endcase
                        if (w_phase_ack) begin
                            w_ack_nx   = 1'b1;
                            w_hold_nx  = c_hold_load;
                            w_state_nx = ST_ACK_HI;
                        end
                    end
                end
                ST_ACK_HI: begin
                    if (r_hold == '0) begin
                        w_state_nx = ST_WAIT_REQ_LO;
                    end else begin
                        w_hold_nx = r_hold - 1'b1;
                    end
                end
                ST_WAIT_REQ_LO: begin
                    if (!i_req) begin
                        w_ack_nx   = 1'b0;
                        w_state_nx = ST_WAIT_REQ;
                    end
                end
                ST_BUS_RESET: begin
                    if (r_rst_cnt == '0) begin
                        w_rst_nx     = 1'b0;
                        w_timeout_nx = 1'b1;
                        w_done_nx    = 1'b1;
                        w_error_nx   = 1'b1;
                        w_busy_nx    = 1'b0;
                        w_state_nx   = ST_IDLE;
                    end else begin
                        w_rst_cnt_nx = r_rst_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= 4'd0;
            r_idx       <= 4'd0;
            r_hold      <= '0;
            r_rst_cnt   <= '0;
            r_msg_seen  <= 1'b0;
            r_sel       <= 1'b0;
            r_ack       <= 1'b0;
            r_rst       <= 1'b0;
            r_db        <= 8'h00;
            r_din_data  <= 8'h00;
            r_din_valid <= 1'b0;
            r_status    <= 8'h00;
            r_message   <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_len       <= w_len_nx;
            r_idx       <= w_idx_nx;
            r_hold      <= w_hold_nx;
            r_rst_cnt   <= w_rst_cnt_nx;
            r_msg_seen  <= w_msg_seen_nx;
            r_sel       <= w_sel_nx;
            r_ack       <= w_ack_nx;
            r_rst       <= w_rst_nx;
            r_db        <= w_db_nx;
            r_din_data  <= w_din_data_nx;
            r_din_valid <= w_din_valid_nx;
            r_status    <= w_status_nx;
            r_message   <= w_message_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
            r_error     <= w_error_nx;
            r_timeout   <= w_timeout_nx;
        end
    end

    assign o_sel       = r_sel;
    assign o_ack       = r_ack;
    assign o_rst       = r_rst;
    assign o_db        = r_db;
    assign o_din_data  = r_din_data;
    assign o_din_valid = r_din_valid;
    assign o_status    = r_status;
    assign o_message   = r_message;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pcecd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcecd_initiator
// Purpose  : Self-checking bench: scripted/randomized target against a
//            transaction-level reference of the initiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcecd_initiator;
    import pcecd_pkg::*;

    localparam int CMD_MAX_LEN    = 10;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int ACK_HOLD       = 2;
    localparam int RST_CYCLES     = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_wr;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [3:0] cmd_len;
    logic       start;
    logic       bsy, req, msg, cd, io;
    logic [7:0] db_t;
    logic       din_ready;
    logic       o_sel, o_ack, o_rst, o_din_valid, o_busy, o_done, o_error, o_timeout;
    logic [7:0] o_db, o_din_data, o_status, o_message;

    always #5 clk = ~clk;

    pcecd_initiator #(
        .CMD_MAX_LEN    (CMD_MAX_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ACK_HOLD       (ACK_HOLD),
        .RST_CYCLES     (RST_CYCLES)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_wr    (cmd_wr),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_data  (cmd_data),
        .i_cmd_len   (cmd_len),
        .i_start     (start),
        .i_bsy       (bsy),
        .i_req       (req),
        .i_msg       (msg),
        .i_cd        (cd),
        .i_io        (io),
        .i_db        (db_t),
        .o_sel       (o_sel),
        .o_ack       (o_ack),
        .o_rst       (o_rst),
        .o_db        (o_db),
        .o_din_data  (o_din_data),
        .o_din_valid (o_din_valid),
        .i_din_ready (din_ready),
        .o_status    (o_status),
        .o_message   (o_message),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_timeout   (o_timeout)
    );

    typedef struct {
        logic [2:0] ph;
        logic [7:0] d;
        int         stall;
    } item_t;

    int         vectors     = 0;
    int         miscompares = 0;
    int         done_cnt    = 0;
    int         tmo_cnt     = 0;
    logic [7:0] rx_q[$];
    item_t      script[$];
    logic [7:0] cmd_ref [CMD_MAX_LEN];
    logic [7:0] ref_status  = 8'h00;
    logic [7:0] ref_message = 8'h00;

    // Passive monitor: pulse counters and the accepted data-in stream
    always @(negedge clk) begin
        if (o_done)    done_cnt++;
        if (o_timeout) tmo_cnt++;
        if (o_din_valid && din_ready) rx_q.push_back(o_din_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [2:0] ph, input logic [7:0] d, input int stall);
        item_t it;
        it.ph = ph; it.d = d; it.stall = stall;
        script.push_back(it);
    endtask

    task automatic load_cmd(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_wr = 1'b1; cmd_addr = 4'(i); cmd_data = cmd_ref[i];
            step();
        end
        cmd_wr = 1'b1; cmd_addr = 4'(CMD_MAX_LEN + int'($urandom_range(0, 5))); cmd_data = 8'hEE;
        step();
        cmd_wr = 1'b0;
    endtask

    // Target side of one byte: raise REQ in a phase, complete the handshake
    task automatic xfer(input logic [2:0] ph, input logic [7:0] d, input int stall,
                        input bit drop, output logic [7:0] odb, output bit ok);
        int hi;
        {msg, cd, io} = ph; db_t = d; odb = 8'h00; ok = 1'b1;
        step();
        req = 1'b1;
        if (ph == PHASE_DATA_IN) begin
            for (int c = 0; c < 20 && o_din_valid !== 1'b1; c++) step();
            vectors++;
            if (o_din_valid !== 1'b1 || o_din_data !== d) begin
                miscompares++;
                $display("FAIL din_present: valid=%b data=%h, want valid=1 data=%h", o_din_valid, o_din_data, d);
            end
            for (int s = 0; s < stall; s++) begin
                step();
                vectors++;
                if (o_ack !== 1'b0 || o_din_valid !== 1'b1 || o_din_data !== d || o_timeout !== 1'b0) begin
                    miscompares++;
                    $display("FAIL din_stall: ack=%b valid=%b data=%h tmo=%b, want ack=0 valid=1 data=%h tmo=0",
                             o_ack, o_din_valid, o_din_data, o_timeout, d);
                end
            end
            din_ready = 1'b1;
        end
        for (int c = 0; c < 400 && o_ack !== 1'b1; c++) step();
        din_ready = 1'b0;
        vectors++;
        if (o_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_wait: ack=%b, want 1 (phase %b)", o_ack, ph);
            ok = 1'b0;
            req = 1'b0;
            return;
        end
        odb = o_db;
        req = 1'b0;
        if (drop) bsy = 1'b0;
        hi = 0;
        for (int c = 0; c < 20 && o_ack === 1'b1; c++) begin
            hi++;
            step();
        end
        vectors++;
        if (o_ack !== 1'b0 || hi < ACK_HOLD) begin
            miscompares++;
            $display("FAIL ack_release: ack=%b high_cycles=%0d, want ack=0 high_cycles>=%0d", o_ack, hi, ACK_HOLD);
        end
    endtask

    // Full transaction against the current script; expectations come from the
    // bus rules applied per scripted byte.
    task automatic run_txn(input string tag, input int len, input bit wr_during, input bit drop_last);
        int         d0, t0, r0, k;
        bit         exp_err, seen_msg, ok, chk_odb;
        logic [7:0] exp_din[$];
        logic [7:0] odb, exp_odb;
        d0 = done_cnt; t0 = tmo_cnt; r0 = rx_q.size();
        k = 0; exp_err = 1'b0; seen_msg = 1'b0; exp_odb = 8'h00;

        cmd_len = 4'(len); start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 10 && o_sel !== 1'b1; c++) step();
        vectors++;
        if (o_sel !== 1'b1 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s select: sel=%b busy=%b, want 1 1", tag, o_sel, o_busy);
        end
        if (wr_during) begin
            cmd_wr = 1'b1; cmd_addr = 4'd0; cmd_data = ~cmd_ref[0];
            cmd_len = 4'd0; start = 1'b1;
            step();
            cmd_wr = 1'b0; start = 1'b0;
        end
        repeat ($urandom_range(0, 2)) step();
        bsy = 1'b1;
        step();
        vectors++;
        if (o_sel !== 1'b0) begin
            miscompares++;
            $display("FAIL %s sel_release: sel=%b, want 0", tag, o_sel);
        end

        foreach (script[i]) begin
            chk_odb = 1'b0;
            case (script[i].ph)
                PHASE_COMMAND: begin
                    chk_odb = 1'b1;
                    if (k < len) exp_odb = cmd_ref[k];
                    else begin exp_odb = 8'h00; exp_err = 1'b1; end
                    k++;
                end
                PHASE_DATA_IN:    exp_din.push_back(script[i].d);
                PHASE_STATUS:     ref_status = script[i].d;
                PHASE_MESSAGE_IN: begin ref_message = script[i].d; seen_msg = 1'b1; end
                default: begin chk_odb = 1'b1; exp_odb = 8'h00; exp_err = 1'b1; end
            endcase
            xfer(script[i].ph, script[i].d, script[i].stall,
                 drop_last && (i == script.size() - 1), odb, ok);
            if (!ok) break;
            if (chk_odb) begin
                vectors++;
                if (odb !== exp_odb) begin
                    miscompares++;
                    $display("FAIL %s odb[%0d]: got %h, want %h", tag, i, odb, exp_odb);
                end
            end
            repeat ($urandom_range(0, 2)) step();
        end

        bsy = 1'b0; req = 1'b0; {msg, cd, io} = 3'b000;
        for (int c = 0; c < 20 && done_cnt == d0; c++) step();
        step();
        if (!seen_msg) exp_err = 1'b1;

        vectors++;
        if (done_cnt - d0 != 1 || tmo_cnt != t0) begin
            miscompares++;
            $display("FAIL %s done_pulses: done=%0d tmo=%0d, want 1 0", tag, done_cnt - d0, tmo_cnt - t0);
        end
        vectors++;
        if (o_error !== exp_err || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end_flags: error=%b busy=%b, want %b 0", tag, o_error, o_busy, exp_err);
        end
        vectors++;
        if (o_status !== ref_status || o_message !== ref_message) begin
            miscompares++;
            $display("FAIL %s status_msg: got %h %h, want %h %h", tag, o_status, o_message, ref_status, ref_message);
        end
        vectors++;
        if (rx_q.size() - r0 != exp_din.size()) begin
            miscompares++;
            $display("FAIL %s din_count: got %0d, want %0d", tag, rx_q.size() - r0, exp_din.size());
        end else begin
            foreach (exp_din[j]) begin
                vectors++;
                if (rx_q[r0 + j] !== exp_din[j]) begin
                    miscompares++;
                    $display("FAIL %s din[%0d]: got %h, want %h", tag, j, rx_q[r0 + j], exp_din[j]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        vectors++;
        if ({o_sel, o_ack, o_rst, o_busy, o_done, o_error, o_timeout, o_din_valid} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, want 00000000",
                     {o_sel, o_ack, o_rst, o_busy, o_done, o_error, o_timeout, o_din_valid});
        end
        vectors++;
        if ({o_db, o_din_data, o_status, o_message} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, want 00000000", {o_db, o_din_data, o_status, o_message});
        end
        rst_n = 1'b1;
        repeat (2) step();
        vectors++;
        if ({o_sel, o_busy, o_done, o_error} !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_release: got %b, want 0000", {o_sel, o_busy, o_done, o_error});
        end
    endtask

    task automatic build_read6(input int stall_idx, input int stall_len, input int ncmd);
        logic [7:0] din [4];
        din[0] = 8'hA5; din[1] = 8'h5A; din[2] = 8'h00; din[3] = 8'hFF;
        cmd_ref[0] = 8'h08; cmd_ref[1] = 8'h00; cmd_ref[2] = 8'h00;
        cmd_ref[3] = 8'h10; cmd_ref[4] = 8'h01; cmd_ref[5] = 8'h00;
        load_cmd(6);
        script.delete();
        for (int i = 0; i < ncmd; i++) add(PHASE_COMMAND, 8'h00, 0);
        if (ncmd == 6) begin
            for (int i = 0; i < 4; i++) add(PHASE_DATA_IN, din[i], (i == stall_idx) ? stall_len : 0);
        end
        add(PHASE_STATUS, 8'h00, 0);
        add(PHASE_MESSAGE_IN, 8'h00, 0);
    endtask

    task automatic test_read6();
        build_read6(-1, 0, 6);
        run_txn("read6", 6, 1'b0, 1'b0);
    endtask

    task automatic test_din_stall();
        build_read6(2, 20, 6);
        run_txn("din_stall", 6, 1'b0, 1'b0);
    endtask

    task automatic test_cmd_overrun();
        build_read6(-1, 0, 7);
        run_txn("cmd_overrun", 6, 1'b0, 1'b0);
    endtask

    task automatic test_bad_len();
        int         d0;
        logic [3:0] lens [2];
        lens[0] = 4'd0; lens[1] = 4'd11;
        foreach (lens[i]) begin
            d0 = done_cnt;
            cmd_len = lens[i]; start = 1'b1;
            step();
            start = 1'b0;
            vectors++;
            if (o_done !== 1'b1 || o_error !== 1'b1 || o_sel !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_len_%0d: done=%b error=%b sel=%b, want 1 1 0", lens[i], o_done, o_error, o_sel);
            end
            step();
            vectors++;
            if (o_done !== 1'b0 || o_sel !== 1'b0 || o_busy !== 1'b0 || done_cnt - d0 != 1) begin
                miscompares++;
                $display("FAIL bad_len_after_%0d: done=%b sel=%b busy=%b pulses=%0d, want 0 0 0 1",
                         lens[i], o_done, o_sel, o_busy, done_cnt - d0);
            end
        end
    endtask

    task automatic test_sel_timeout();
        int t0, n, r;
        t0 = tmo_cnt;
        cmd_len = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if (o_sel !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_sel: sel=%b, want 1", o_sel);
        end
        n = 0;
        for (int c = 0; c < 300 && o_rst !== 1'b1; c++) begin
            step();
            n++;
        end
        vectors++;
        if (o_rst !== 1'b1 || o_sel !== 1'b0 || n < TIMEOUT_CYCLES - 3 || n > TIMEOUT_CYCLES + 4) begin
            miscompares++;
            $display("FAIL tmo_latency: rst=%b sel=%b cycles=%0d, want 1 0 ~%0d", o_rst, o_sel, n, TIMEOUT_CYCLES);
        end
        r = 0;
        for (int c = 0; c < 50 && o_rst === 1'b1; c++) begin
            r++;
            step();
        end
        vectors++;
        if (r != RST_CYCLES) begin
            miscompares++;
            $display("FAIL tmo_rst_len: got %0d cycles, want %0d", r, RST_CYCLES);
        end
        vectors++;
        if (o_timeout !== 1'b1 || o_done !== 1'b1 || o_error !== 1'b1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_end: timeout=%b done=%b error=%b busy=%b, want 1 1 1 0",
                     o_timeout, o_done, o_error, o_busy);
        end
        step();
        vectors++;
        if (o_timeout !== 1'b0 || o_done !== 1'b0 || tmo_cnt - t0 != 1 || o_error !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_after: timeout=%b done=%b pulses=%0d error=%b, want 0 0 1 1",
                     o_timeout, o_done, tmo_cnt - t0, o_error);
        end
    endtask

    task automatic test_random();
        int len, ncmd, nd;
        logic [2:0] bad [4];
        bad[0] = PHASE_DATA_OUT; bad[1] = 3'b100; bad[2] = 3'b101; bad[3] = PHASE_MESSAGE_OUT;
        for (int t = 0; t < 12; t++) begin
            len = int'($urandom_range(1, CMD_MAX_LEN));
            for (int i = 0; i < len; i++) cmd_ref[i] = 8'($urandom);
            load_cmd(len);
            script.delete();
            ncmd = len + (($urandom_range(0, 3) == 0) ? 1 : 0);
            for (int i = 0; i < ncmd; i++) add(PHASE_COMMAND, 8'($urandom), 0);
            nd = int'($urandom_range(0, 5));
            for (int i = 0; i < nd; i++)
                add(PHASE_DATA_IN, 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(101, 150)) : int'($urandom_range(0, 3)));
            if ($urandom_range(0, 5) == 0) add(bad[$urandom_range(0, 3)], 8'($urandom), 0);
            add(PHASE_STATUS, 8'($urandom), 0);
            if ($urandom_range(0, 5) != 0) add(PHASE_MESSAGE_IN, 8'($urandom), 0);
            run_txn("random", len, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
            repeat (2) step();
        end
    endtask

    task automatic test_async_reset();
        cmd_len = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        bsy = 1'b1;
        step();
        {msg, cd, io} = PHASE_COMMAND;
        step();
        req = 1'b1;
        for (int c = 0; c < 20 && o_ack !== 1'b1; c++) step();
        vectors++;
        if (o_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_setup: ack=%b, want 1", o_ack);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_ack, o_sel, o_busy, o_rst} !== 4'b0000) begin
            miscompares++;
            $display("FAIL arst_immediate: ack/sel/busy/rst=%b, want 0000", {o_ack, o_sel, o_busy, o_rst});
        end
        req = 1'b0; bsy = 1'b0; {msg, cd, io} = 3'b000;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        ref_status = 8'h00; ref_message = 8'h00;
        vectors++;
        if (o_busy !== 1'b0 || o_status !== 8'h00 || o_db !== 8'h00) begin
            miscompares++;
            $display("FAIL arst_release: busy=%b status=%h db=%h, want 0 00 00", o_busy, o_status, o_db);
        end
        cmd_len = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if (o_done !== 1'b1 || o_error !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_idle: done=%b error=%b, want 1 1", o_done, o_error);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_wr = 1'b0; cmd_addr = 4'd0; cmd_data = 8'h00; cmd_len = 4'd0;
        start = 1'b0; bsy = 1'b0; req = 1'b0; msg = 1'b0; cd = 1'b0; io = 1'b0;
        db_t = 8'h00; din_ready = 1'b0;
        test_reset();
        test_read6();
        test_din_stall();
        test_cmd_overrun();
        test_bad_len();
        test_sel_timeout();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
